// File: rtl/sm_alu_pkg.sv
// Shared types for the sign-magnitude ALU: opcodes, FSM states and sign-bit position.
package sm_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD    = 3'b000,
    OP_SUB    = 3'b001,
    OP_PASS_A = 3'b010,
    OP_PASS_B = 3'b011,
    OP_MUL    = 3'b100
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Sign sits directly above the magnitude.
  function automatic int sign_idx(input int mag_w);
    return mag_w;
  endfunction

endpackage

// File: rtl/sm_mag_addsub.sv
// Combinational sign-magnitude add: same signs add, different signs subtract smaller from larger.
// Zero latency; carry flags magnitude overflow; no flow control.
module sm_mag_addsub #(
  parameter int MAG_W = 8
) (
  input  logic             sign_a,
  input  logic [MAG_W-1:0] mag_a,
  input  logic             sign_b,
  input  logic [MAG_W-1:0] mag_b,
  output logic             sign,
  output logic [MAG_W-1:0] mag,
  output logic             carry
);

  logic [MAG_W:0] sum;

  always_comb begin
    sum  = '0;
    sign = 1'b0;
    if (sign_a == sign_b) begin
      sum  = {1'b0, mag_a} + {1'b0, mag_b};
      sign = sign_a;
    end else if (mag_a >= mag_b) begin
      sum  = {1'b0, mag_a - mag_b};
      sign = sign_a;
    end else begin
      sum  = {1'b0, mag_b - mag_a};
      sign = sign_b;
    end
  end

  assign mag   = sum[MAG_W-1:0];
  assign carry = sum[MAG_W];

endmodule

// File: rtl/sm_alu_seq.sv
// Sign-magnitude ALU, valid/ready both sides; 1 cycle for ADD/SUB/PASS, MAG_W+1 for shift-add MUL.
// Result held in DONE until out_ready; in_ready only in IDLE. ALU_SAT_EN saturates on overflow, else wraps.
module sm_alu_seq
  import sm_alu_pkg::*;
#(
  parameter int MAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [MAG_W:0]   in_a,
  input  logic [MAG_W:0]   in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAG_W:0]   out_result,
  output logic             out_ovf,
  output logic             out_err
);

  localparam int SB    = sign_idx(MAG_W);
  localparam int CNT_W = $clog2(MAG_W + 1);

  localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
  localparam logic [1:0] S_MUL  = 2'(ST_MUL);
  localparam logic [1:0] S_DONE = 2'(ST_DONE);

  logic [1:0]           state;
  op_t                  op_e;
  logic [MAG_W-1:0]     mag_a, mag_b;
  logic                 sgn_a, sgn_b, sgn_b_eff;
  logic                 as_sign, as_carry;
  logic [MAG_W-1:0]     as_mag;
  logic [MAG_W-1:0]     add_mag;
  logic [MAG_W:0]       single_res;
  logic                 single_ovf, single_err;
  logic [2*MAG_W-1:0]   mcand, acc, acc_next;
  logic [MAG_W-1:0]     mplier;
  logic [CNT_W-1:0]     cnt;
  logic                 mul_sign, mul_ovf;
  logic [MAG_W-1:0]     mul_mag;
  logic [MAG_W:0]       mul_res;

  assign op_e     = op_t'(op);
  assign in_ready = (state == S_IDLE);

  // -0 operands are folded to +0 before any sign decision.
  assign mag_a     = in_a[MAG_W-1:0];
  assign mag_b     = in_b[MAG_W-1:0];
  assign sgn_a     = in_a[SB] & (mag_a != '0);
  assign sgn_b     = in_b[SB] & (mag_b != '0);
  assign sgn_b_eff = (op_e == OP_SUB) ? ~sgn_b : sgn_b;

  sm_mag_addsub #(.MAG_W(MAG_W)) u_addsub (
    .sign_a (sgn_a),
    .mag_a  (mag_a),
    .sign_b (sgn_b_eff),
    .mag_b  (mag_b),
    .sign   (as_sign),
    .mag    (as_mag),
    .carry  (as_carry)
  );

  always_comb begin
    add_mag = as_mag;
`ifdef ALU_SAT_EN
    if (as_carry) add_mag = '1;
`endif
    single_res = '0;
    single_ovf = 1'b0;
    single_err = 1'b0;
    case (op_e)
      OP_ADD, OP_SUB: begin
        single_res = {as_sign & (add_mag != '0), add_mag};
        single_ovf = as_carry;
      end
      OP_PASS_A: single_res = {sgn_a, mag_a};
      OP_PASS_B: single_res = {sgn_b, mag_b};
      default:   single_err = 1'b1;
    endcase
  end

  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign mul_ovf  = (acc_next[2*MAG_W-1:MAG_W] != '0);

  always_comb begin
    mul_mag = acc_next[MAG_W-1:0];
`ifdef ALU_SAT_EN
    if (mul_ovf) mul_mag = '1;
`endif
    mul_res = {mul_sign & (mul_mag != '0), mul_mag};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_ovf    <= 1'b0;
      out_err    <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      mul_sign   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (op_e == OP_MUL) begin
              mcand    <= {{MAG_W{1'b0}}, mag_a};
              mplier   <= mag_b;
              acc      <= '0;
              cnt      <= '0;
              mul_sign <= sgn_a ^ sgn_b;
              state    <= S_MUL;
            end else begin
              out_result <= single_res;
              out_ovf    <= single_ovf;
              out_err    <= single_err;
              out_valid  <= 1'b1;
              state      <= S_DONE;
            end
          end
        end
        S_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(MAG_W - 1)) begin
            out_result <= mul_res;
            out_ovf    <= mul_ovf;
            out_err    <= 1'b0;
            out_valid  <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
